// File: rtl/seq_slot_bank.sv
`default_nettype none
// ============================================================================
//  Module      : seq_slot_bank
//  Description : Descriptor slot store for the magic sequencer (bank 1).
//                AXI-lite write/read paths plus sequencer start/done events
//                with a saturating per-slot RUNNING cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_slot_bank #(
    parameter int INDEX_WIDTH   = 3,
    parameter int ADDR_WIDTH    = 32,
    parameter int SIZE_WIDTH    = 26,
    parameter int PROFILE_WIDTH = 32,
    parameter int MSK_WIDTH     = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              wr_en,
    input  logic [INDEX_WIDTH-1:0]                            wr_index,
    input  logic [3:0]                                        wr_field,
    input  logic [DATA_WIDTH-1:0]                             wr_data,
    input  logic                                              rd_req,
    input  logic [INDEX_WIDTH-1:0]                            rd_index,
    output logic [ADDR_WIDTH-1:0]                             rd_src_addr,
    output logic [SIZE_WIDTH-1:0]                             rd_src_size,
    output logic [ADDR_WIDTH-1:0]                             rd_des_addr,
    output logic [SIZE_WIDTH-1:0]                             rd_des_size,
    output logic [1:0]                                        rd_status,
    output logic [PROFILE_WIDTH-1:0]                          rd_profile,
    output logic [MSK_WIDTH-1:0]                              rd_ld_mask,
    output logic [MSK_WIDTH-1:0]                              rd_st_mask,
    output logic [MSK_WIDTH-1:0]                              rd_st_intr_mask,
    output logic                                              rd_ready,
    input  logic [INDEX_WIDTH-1:0]                            seq_index,
    input  logic                                              seq_start,
    input  logic                                              seq_done,
    output logic [2*ADDR_WIDTH+2*SIZE_WIDTH+3*MSK_WIDTH-1:0]  seq_desc
);

    localparam int C_NSLOT = 1 << INDEX_WIDTH;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_RUNNING = 2'd1;
    localparam logic [1:0] C_ST_DONE    = 2'd2;
    localparam logic [1:0] C_ST_ERROR   = 2'd3;

    localparam logic [3:0] C_F_SRC_ADDR = 4'd0;
    localparam logic [3:0] C_F_SRC_SIZE = 4'd1;
    localparam logic [3:0] C_F_DES_ADDR = 4'd2;
    localparam logic [3:0] C_F_DES_SIZE = 4'd3;
    localparam logic [3:0] C_F_STATUS   = 4'd4;
    localparam logic [3:0] C_F_PROFILE  = 4'd5;
    localparam logic [3:0] C_F_LD_MASK  = 4'd6;
    localparam logic [3:0] C_F_ST_MASK  = 4'd7;
    localparam logic [3:0] C_F_SI_MASK  = 4'd8;

    logic [ADDR_WIDTH-1:0]    r_src_addr    [C_NSLOT];
    logic [SIZE_WIDTH-1:0]    r_src_size    [C_NSLOT];
    logic [ADDR_WIDTH-1:0]    r_des_addr    [C_NSLOT];
    logic [SIZE_WIDTH-1:0]    r_des_size    [C_NSLOT];
    logic [1:0]               r_status      [C_NSLOT];
    logic [PROFILE_WIDTH-1:0] r_profile     [C_NSLOT];
    logic [MSK_WIDTH-1:0]     r_ld_mask     [C_NSLOT];
    logic [MSK_WIDTH-1:0]     r_st_mask     [C_NSLOT];
    logic [MSK_WIDTH-1:0]     r_si_mask     [C_NSLOT];

    logic [PROFILE_WIDTH-1:0] w_profile_inc [C_NSLOT];
    logic [PROFILE_WIDTH-1:0] w_profile_nxt [C_NSLOT];
    logic [1:0]               w_status_nxt  [C_NSLOT];

    // Saturating +1 of each counter while its slot is RUNNING, otherwise hold
    always_comb begin
        for (int i = 0; i < C_NSLOT; i++) begin
            w_profile_inc[i] = r_profile[i];
            if ((r_status[i] == C_ST_RUNNING) && (r_profile[i] != '1)) begin
                w_profile_inc[i] = r_profile[i] + PROFILE_WIDTH'(1);
            end
        end
    end

    // Status/profile next state: sequencer events take priority over AXI writes
    always_comb begin
        for (int i = 0; i < C_NSLOT; i++) begin
            w_status_nxt[i]  = r_status[i];
            w_profile_nxt[i] = w_profile_inc[i];
            if (seq_index == INDEX_WIDTH'(i) && seq_start && seq_done) begin
                w_status_nxt[i] = C_ST_ERROR;
            end else if (seq_index == INDEX_WIDTH'(i) && seq_start) begin
                w_status_nxt[i]  = C_ST_RUNNING;
                w_profile_nxt[i] = '0;
            end else if (seq_index == INDEX_WIDTH'(i) && seq_done) begin
                w_status_nxt[i] = C_ST_DONE;
            end else if (wr_en && wr_index == INDEX_WIDTH'(i)) begin
                if (wr_field == C_F_STATUS) begin
                    w_status_nxt[i] = wr_data[1:0];
                end
                // Any write to the profile field clears it, data is ignored
                if (wr_field == C_F_PROFILE) begin
                    w_profile_nxt[i] = '0;
                end
            end
        end
    end

    // Slot storage: descriptor fields from AXI writes, status/profile from next-state logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C_NSLOT; i++) begin
                r_src_addr[i] <= '0;
                r_src_size[i] <= '0;
                r_des_addr[i] <= '0;
                r_des_size[i] <= '0;
                r_status[i]   <= C_ST_IDLE;
                r_profile[i]  <= '0;
                r_ld_mask[i]  <= '0;
                r_st_mask[i]  <= '0;
                r_si_mask[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < C_NSLOT; i++) begin
                r_status[i]  <= w_status_nxt[i];
                r_profile[i] <= w_profile_nxt[i];
            end
            if (wr_en) begin
                case (wr_field)
                    C_F_SRC_ADDR: r_src_addr[wr_index] <= wr_data[ADDR_WIDTH-1:0];
                    C_F_SRC_SIZE: r_src_size[wr_index] <= wr_data[SIZE_WIDTH-1:0];
                    C_F_DES_ADDR: r_des_addr[wr_index] <= wr_data[ADDR_WIDTH-1:0];
                    C_F_DES_SIZE: r_des_size[wr_index] <= wr_data[SIZE_WIDTH-1:0];
                    C_F_LD_MASK:  r_ld_mask[wr_index]  <= wr_data[MSK_WIDTH-1:0];
                    C_F_ST_MASK:  r_st_mask[wr_index]  <= wr_data[MSK_WIDTH-1:0];
                    C_F_SI_MASK:  r_si_mask[wr_index]  <= wr_data[MSK_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read port: capture the pre-edge slot contents whenever a request is present
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_src_addr     <= '0;
            rd_src_size     <= '0;
            rd_des_addr     <= '0;
            rd_des_size     <= '0;
            rd_status       <= '0;
            rd_profile      <= '0;
            rd_ld_mask      <= '0;
            rd_st_mask      <= '0;
            rd_st_intr_mask <= '0;
            rd_ready        <= 1'b0;
        end else begin
            rd_ready <= rd_req;
            if (rd_req) begin
                rd_src_addr     <= r_src_addr[rd_index];
                rd_src_size     <= r_src_size[rd_index];
                rd_des_addr     <= r_des_addr[rd_index];
                rd_des_size     <= r_des_size[rd_index];
                rd_status       <= r_status[rd_index];
                rd_profile      <= r_profile[rd_index];
                rd_ld_mask      <= r_ld_mask[rd_index];
                rd_st_mask      <= r_st_mask[rd_index];
                rd_st_intr_mask <= r_si_mask[rd_index];
            end
        end
    end

    assign seq_desc = {r_si_mask[seq_index], r_st_mask[seq_index], r_ld_mask[seq_index],
                       r_des_size[seq_index], r_des_addr[seq_index],
                       r_src_size[seq_index], r_src_addr[seq_index]};

endmodule
`default_nettype wire
